// File: rtl/rob_field_bank_store.sv
// rob_field_bank_store
//   Banked register storage for one reorder-buffer field. NBANK banks of
//   DEPTH entries, WIDTH bits each, addressed by {bank, index}.
//   A clear sweep writes INIT to one row of every bank per cycle. It runs
//   after reset and after a flush. The store only serves requests once the
//   sweep is complete.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset (enters SWEEP, clears read outputs)
//   flush   : request a full clear sweep; drops same-cycle writes and reads
//   ready   : 1 while in RUN (sweep complete)
//   wen     : per-port write enable                      [NWR]
//   wbank   : per-port bank select, port k at [k*BANK_W +: BANK_W]
//   windex  : per-port entry index,  port k at [k*IDX_W  +: IDX_W]
//   wdata   : per-port write data,   port k at [k*WIDTH  +: WIDTH]
//   ren     : per-port read enable                       [NRD]
//   rbank   : per-port read bank select
//   rindex  : per-port read entry index
//   rdata   : registered read data (zero when no read was accepted)
//   rvalid  : registered read-data valid
module rob_field_bank_store #(
  parameter int              NBANK  = 4,
  parameter int              DEPTH  = 128,
  parameter int              WIDTH  = 32,
  parameter int              NWR    = 4,
  parameter int              NRD    = 4,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter bit              BYPASS = 1'b1,
  localparam int             BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int             IDX_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  output logic                   ready,
  input  logic [NWR-1:0]         wen,
  input  logic [NWR*BANK_W-1:0]  wbank,
  input  logic [NWR*IDX_W-1:0]   windex,
  input  logic [NWR*WIDTH-1:0]   wdata,
  input  logic [NRD-1:0]         ren,
  input  logic [NRD*BANK_W-1:0]  rbank,
  input  logic [NRD*IDX_W-1:0]   rindex,
  output logic [NRD*WIDTH-1:0]   rdata,
  output logic [NRD-1:0]         rvalid
);

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_mem [NBANK][DEPTH];

  logic [BANK_W-1:0]  w_wbank [NWR];
  logic [IDX_W-1:0]   w_widx  [NWR];
  logic [WIDTH-1:0]   w_wdata [NWR];
  logic [BANK_W-1:0]  w_rbank [NRD];
  logic [IDX_W-1:0]   w_ridx  [NRD];
  logic [WIDTH-1:0]   w_rd    [NRD];

  logic               w_run;
  logic               w_sweep_wr;
  logic [NRD*WIDTH-1:0] w_rdata_nxt, r_rdata;
  logic [NRD-1:0]       w_rvalid_nxt, r_rvalid;

  // Unpack port buses. With a single bank the bank field is forced to 0 so
  // a stray select bit can never address past the array.
  always_comb begin
    for (int unsigned k = 0; k < NWR; k++) begin
      w_wbank[k] = (NBANK > 1) ? wbank[k*BANK_W +: BANK_W] : '0;
      w_widx[k]  = windex[k*IDX_W +: IDX_W];
      w_wdata[k] = wdata[k*WIDTH +: WIDTH];
    end
    for (int unsigned j = 0; j < NRD; j++) begin
      w_rbank[j] = (NBANK > 1) ? rbank[j*BANK_W +: BANK_W] : '0;
      w_ridx[j]  = rindex[j*IDX_W +: IDX_W];
    end
  end

  // Sweep / run sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_SWEEP: begin
        if (flush) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SWEEP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_run      = (r_state == ST_RUN) && !flush;
  assign w_sweep_wr = (r_state == ST_SWEEP) && !flush;
  assign ready      = (r_state == ST_RUN);

  // Storage. Ports are applied in ascending order so the highest-numbered
  // port's nonblocking assignment is the one that lands on a shared entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_sweep_wr) begin
        for (int unsigned b = 0; b < NBANK; b++) begin
          r_mem[b][r_cnt] <= INIT;
        end
      end
      if (w_run) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wen[k]) begin
            r_mem[w_wbank[k]][w_widx[k]] <= w_wdata[k];
          end
        end
      end
    end
  end

  // Read path: stored value, optionally overridden by the winning
  // same-cycle write (later ports override earlier ones).
  always_comb begin
    for (int unsigned j = 0; j < NRD; j++) begin
      w_rd[j] = r_mem[w_rbank[j]][w_ridx[j]];
      if (BYPASS) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wen[k] && (w_wbank[k] == w_rbank[j]) && (w_widx[k] == w_ridx[j])) begin
            w_rd[j] = w_wdata[k];
          end
        end
      end
    end
  end

  always_comb begin
    w_rdata_nxt  = '0;
    w_rvalid_nxt = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      if (w_run && ren[j]) begin
        w_rvalid_nxt[j]               = 1'b1;
        w_rdata_nxt[j*WIDTH +: WIDTH] = w_rd[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else begin
      r_rdata  <= w_rdata_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule
